// File: rtl/ldst_arb_pkg.sv
// Shared constants and types for the load/store multi-channel arbiter.
package ldst_arb_pkg;

  // Access size encoding carried on the ORDER fields
  localparam logic [1:0] LDST_BYTE = 2'b00;
  localparam logic [1:0] LDST_HALF = 2'b01;
  localparam logic [1:0] LDST_WORD = 2'b10;
  localparam logic [1:0] LDST_NONE = 2'b11;

  // Channel identifier for the default three-channel configuration
  localparam int unsigned N_CH_DEFAULT = 3;
  typedef logic [$clog2(N_CH_DEFAULT)-1:0] ch_id_t;

endpackage

// File: rtl/ldst_id_fifo.sv
// Small synchronous FIFO holding the issuing channel of each outstanding
// load/store transaction. Push is ignored when full, pop when empty.
module ldst_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written on every accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_multi_arbiter.sv
// N-channel round-robin arbiter in front of the single load/store port.
// Accepted transactions record their channel in an ID FIFO so that the
// in-order responses can be steered back to the issuing channel.
module load_store_multi_arbiter
  import ldst_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                            iCLOCK,
  input  logic                            inRESET,
  input  logic                            iRESET_SYNC,
  input  logic                            iFORCE_EN,
  input  logic [$clog2(N_CH)-1:0]         iFORCE_SEL,
  input  logic [N_CH-1:0]                 iCH_REQ,
  output logic [N_CH-1:0]                 oCH_BUSY,
  input  logic [2*N_CH-1:0]               iCH_ORDER,
  input  logic [(DATA_W/8)*N_CH-1:0]      iCH_MASK,
  input  logic [N_CH-1:0]                 iCH_RW,
  input  logic [ADDR_W*N_CH-1:0]          iCH_ADDR,
  input  logic [DATA_W*N_CH-1:0]          iCH_DATA,
  output logic [N_CH-1:0]                 oCH_VALID,
  output logic [DATA_W-1:0]               oCH_DATA,
  output logic                            oLDST_REQ,
  output logic [1:0]                      oLDST_ORDER,
  output logic [DATA_W/8-1:0]             oLDST_MASK,
  output logic                            oLDST_RW,
  output logic [ADDR_W-1:0]               oLDST_ADDR,
  output logic [DATA_W-1:0]               oLDST_DATA,
  input  logic                            iLDST_BUSY,
  input  logic                            iLDST_VALID,
  input  logic [DATA_W-1:0]               iLDST_DATA,
  output logic [$clog2(MAX_OUTST):0]      oOUTST_CNT,
  output logic                            oERR_UNEXP
);

  localparam int unsigned CH_W   = $clog2(N_CH);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [N_CH-1:0] CH_ONE = {{(N_CH-1){1'b0}}, 1'b1};

  logic [CH_W-1:0] rr_ptr;
  logic [N_CH-1:0] eligible;
  logic [CH_W:0]   pick;
  logic [CH_W-1:0] grant_id;
  logic            grant_vld;
  logic            accept;
  logic            resp_pop;
  logic [CH_W-1:0] head_id;
  logic            fifo_full;
  logic            fifo_empty;
  logic            err_unexp;

  // First eligible channel at or after ptr, wrapping; MSB flags a hit
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] elig,
                                            input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    logic [CH_W:0] idx;
    res = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
      if (!res[CH_W] && elig[idx[CH_W-1:0]]) res = {1'b1, idx[CH_W-1:0]};
    end
    return res;
  endfunction

  // Eligibility, grant and issue-side field multiplexing
  always_comb begin
    eligible    = iFORCE_EN ? (iCH_REQ & (CH_ONE << iFORCE_SEL)) : iCH_REQ;
    pick        = rr_pick(eligible, rr_ptr);
    grant_id    = pick[CH_W-1:0];
    grant_vld   = pick[CH_W] && !fifo_full;
    accept      = grant_vld && !iLDST_BUSY;
    oLDST_REQ   = grant_vld;
    oLDST_ORDER = '0;
    oLDST_MASK  = '0;
    oLDST_RW    = 1'b0;
    oLDST_ADDR  = '0;
    oLDST_DATA  = '0;
    if (grant_vld) begin
      oLDST_ORDER = iCH_ORDER[int'(grant_id)*2 +: 2];
      oLDST_MASK  = iCH_MASK[int'(grant_id)*MASK_W +: MASK_W];
      oLDST_RW    = iCH_RW[grant_id];
      oLDST_ADDR  = iCH_ADDR[int'(grant_id)*ADDR_W +: ADDR_W];
      oLDST_DATA  = iCH_DATA[int'(grant_id)*DATA_W +: DATA_W];
    end
    oCH_BUSY  = accept ? ~(CH_ONE << grant_id) : '1;
    resp_pop  = iLDST_VALID && !fifo_empty;
    oCH_VALID = resp_pop ? (CH_ONE << head_id) : '0;
    oCH_DATA  = iLDST_DATA;
  end

  // Round-robin pointer and sticky unexpected-response flag
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rr_ptr    <= '0;
      err_unexp <= 1'b0;
    end else if (iRESET_SYNC) begin
      rr_ptr    <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (accept)
        rr_ptr <= (grant_id == CH_W'(N_CH-1)) ? '0 : grant_id + CH_W'(1);
      if (iLDST_VALID && fifo_empty)
        err_unexp <= 1'b1;
    end
  end

  assign oERR_UNEXP = err_unexp;

  ldst_id_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk   (iCLOCK),
    .rst_n (inRESET),
    .clr   (iRESET_SYNC),
    .push  (accept),
    .din   (grant_id),
    .pop   (resp_pop),
    .dout  (head_id),
    .count (oOUTST_CNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
